// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_sched
// Purpose  : Round-robin ALU/LSU writeback arbiter driving a registered
//            single-port register-file write, plus a RAW busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  input  logic            issue_set,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [NREG-1:0] busy_vec,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  localparam int c_IDXW = 5;

  logic            r_last_lsu;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wd;
  logic [NREG-1:0] r_busy;

  logic            w_alu_gnt;
  logic            w_lsu_gnt;
  logic [4:0]      w_gnt_rd;
  logic [XLEN-1:0] w_gnt_wd;
  logic [NREG-1:0] w_busy_nxt;

  // Grants look only at valids and history, never at the other ready.
  assign w_alu_gnt = rst_n & alu_valid & (~lsu_valid | r_last_lsu);
  assign w_lsu_gnt = rst_n & lsu_valid & (~alu_valid | ~r_last_lsu);
  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;

  assign w_gnt_rd = w_alu_gnt ? alu_rd : lsu_rd;
  assign w_gnt_wd = w_alu_gnt ? alu_wd : lsu_wd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_lsu <= 1'b1;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_wd       <= '0;
    end else if (w_alu_gnt || w_lsu_gnt) begin
      r_last_lsu <= w_lsu_gnt;
      r_we       <= (w_gnt_rd != '0);
      r_rd       <= w_gnt_rd;
      r_wd       <= w_gnt_wd;
    end else begin
      r_we       <= 1'b0;
    end
  end

  // Set is applied after clear so a re-issued producer keeps the bit.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NREG; i++) begin
      if (r_we && (r_rd == c_IDXW'(i)))
        w_busy_nxt[i] = 1'b0;
      if (issue_set && (issue_rd == c_IDXW'(i)))
        w_busy_nxt[i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1 == c_IDXW'(i))
        rs1_busy = r_busy[i];
      if (rs2 == c_IDXW'(i))
        rs2_busy = r_busy[i];
    end
  end

  assign busy_vec = r_busy;
  assign rf_we    = r_we;
  assign rf_rd    = r_rd;
  assign rf_wd    = r_wd;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_sched
// Purpose  : Directed and randomized self-checking bench for regfile_wb_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int c_ALU = 0;
  localparam int c_LSU = 1;

  logic            clk;
  logic            rst_n;
  logic            alu_valid, lsu_valid;
  logic            alu_ready, lsu_ready;
  logic [4:0]      alu_rd, lsu_rd, issue_rd, rs1, rs2, rf_rd;
  logic [XLEN-1:0] alu_wd, lsu_wd, rf_wd;
  logic            issue_set, rs1_busy, rs2_busy, rf_we;
  logic [NREG-1:0] busy_vec;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              m_last;
  logic [31:0]     m_busy;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  logic            m_alu_xfer, m_lsu_xfer;

  regfile_wb_sched #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .issue_set(issue_set), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_alu_rdy();
    if (!rst_n || !alu_valid) return 1'b0;
    if (!lsu_valid) return 1'b1;
    return (m_last == c_LSU);
  endfunction

  function automatic logic exp_lsu_rdy();
    if (!rst_n || !lsu_valid) return 1'b0;
    if (!alu_valid) return 1'b1;
    return (m_last == c_ALU);
  endfunction

  // Apply the spec rules for one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic ga, gl;
    logic [31:0] nb;
    ga = exp_alu_rdy();
    gl = exp_lsu_rdy();
    nb = m_busy;
    if (m_we) nb[m_rd] = 1'b0;
    if (issue_set && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
    nb[0] = 1'b0;
    if (!rst_n) begin
      m_last = c_LSU; m_we = 1'b0; m_rd = '0; m_wd = '0; m_busy = '0;
    end else begin
      m_busy = nb;
      if (ga) begin
        m_last = c_ALU; m_rd = alu_rd; m_wd = alu_wd; m_we = (alu_rd != 5'd0);
      end else if (gl) begin
        m_last = c_LSU; m_rd = lsu_rd; m_wd = lsu_wd; m_we = (lsu_rd != 5'd0);
      end else begin
        m_we = 1'b0;
      end
    end
    m_alu_xfer = ga;
    m_lsu_xfer = gl;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; issue_set = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; alu_wd = 0; lsu_wd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    alu_valid = 1; lsu_valid = 1; alu_rd = 5'd3; lsu_rd = 5'd4;
    tick();
    tick();
    checks++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: alu=%b lsu=%b expected 0/0", alu_ready, lsu_ready);
    end
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== '0) begin
      errors++; $display("FAIL reset_rf: we=%b rd=%0d wd=%h expected 0/0/0", rf_we, rf_rd, rf_wd);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec);
    end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_basic();
    issue_set = 1; issue_rd = 5'd5; rs1 = 5'd5;
    tick();
    issue_set = 0;
    checks++;
    if (busy_vec[5] !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++; $display("FAIL basic_set: busy5=%b rs1_busy=%b expected 1/1", busy_vec[5], rs1_busy);
    end
    alu_valid = 1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready: alu=%b lsu=%b expected 1/0", alu_ready, lsu_ready);
    end
    tick();
    alu_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_write: we=%b rd=%0d wd=%h expected 1/5/deadbeef", rf_we, rf_rd, rf_wd);
    end
    checks++;
    if (busy_vec[5] !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_hold: busy5=%b rs1_busy=%b expected 1/1", busy_vec[5], rs1_busy);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || busy_vec[5] !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL basic_clear: we=%b busy5=%b rs1_busy=%b expected 0/0/0", rf_we, busy_vec[5], rs1_busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    alu_valid = 1; lsu_valid = 1;
    alu_rd = 5'd1; alu_wd = 32'hA000_0000;
    lsu_rd = 5'd2; lsu_wd = 32'hB000_0000;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      #1;
      checks++;
      if (alu_ready !== exp_a || lsu_ready !== !exp_a) begin
        errors++; $display("FAIL rr_grant%0d: alu=%b lsu=%b expected %b/%b", k, alu_ready, lsu_ready, exp_a, !exp_a);
      end
      tick();
      checks++;
      if (rf_rd !== (exp_a ? 5'd1 : 5'd2) || rf_we !== 1'b1 || rf_wd !== m_wd) begin
        errors++; $display("FAIL rr_write%0d: rd=%0d we=%b wd=%h expected %0d/1/%h", k, rf_rd, rf_we, rf_wd, exp_a ? 1 : 2, m_wd);
      end
      if (exp_a) alu_wd = alu_wd + 1; else lsu_wd = lsu_wd + 1;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    lsu_valid = 1; lsu_rd = 5'd0; lsu_wd = 32'h1234;
    #1;
    checks++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL x0_ready: lsu=%b alu=%b expected 1/0", lsu_ready, alu_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_we: got %b expected 0", rf_we);
    end
    alu_valid = 1; alu_rd = 5'd9; lsu_rd = 5'd10;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL x0_next_grant: alu=%b lsu=%b expected 1/0", alu_ready, lsu_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_set_clear();
    do_reset();
    issue_set = 1; issue_rd = 5'd7;
    tick();
    issue_set = 0; lsu_valid = 1; lsu_rd = 5'd7; lsu_wd = 32'h77;
    tick();
    lsu_valid = 0; issue_set = 1; issue_rd = 5'd7;
    tick();
    checks++;
    if (busy_vec[7] !== 1'b1) begin
      errors++; $display("FAIL set_wins: busy7=%b expected 1", busy_vec[7]);
    end
    issue_set = 0; lsu_valid = 1; lsu_rd = 5'd7; lsu_wd = 32'h78;
    tick();
    lsu_valid = 0; issue_set = 1; issue_rd = 5'd8;
    tick();
    checks++;
    if (busy_vec[7] !== 1'b0 || busy_vec[8] !== 1'b1) begin
      errors++; $display("FAIL set_clear_diff: busy7=%b busy8=%b expected 0/1", busy_vec[7], busy_vec[8]);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    issue_set = 1; issue_rd = 5'd3;
    tick();
    issue_set = 0; alu_valid = 1; alu_rd = 5'd3; alu_wd = 32'h3333;
    tick();
    rst_n = 0; alu_valid = 1; lsu_valid = 1; lsu_rd = 5'd4;
    #1;
    checks++;
    if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready: alu=%b lsu=%b expected 0/0", alu_ready, lsu_ready);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || busy_vec !== '0) begin
      errors++; $display("FAIL rstmid_state: we=%b busy=%h expected 0/0", rf_we, busy_vec);
    end
    rst_n = 1;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_grant: alu=%b lsu=%b expected 1/0", alu_ready, lsu_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_issue();
    do_reset();
    issue_set = 1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    tick();
    issue_set = 0;
    checks++;
    if (busy_vec !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL x0_issue: busy=%h rs1=%b rs2=%b expected 0/0/0", busy_vec, rs1_busy, rs2_busy);
    end
  endtask

  task automatic test_random();
    logic alu_hold, lsu_hold;
    alu_hold = 0; lsu_hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!alu_hold) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = 5'($urandom_range(0, 31)); alu_wd = $urandom;
      end
      if (!lsu_hold) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd = 5'($urandom_range(0, 31)); lsu_wd = $urandom;
      end
      issue_set = ($urandom_range(0, 1) == 1);
      issue_rd = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      rst_n = ($urandom_range(0, 63) != 0);
      #1;
      checks++;
      if (alu_ready !== exp_alu_rdy() || lsu_ready !== exp_lsu_rdy()) begin
        errors++; $display("FAIL rnd_ready@%0d: alu=%b lsu=%b expected %b/%b", n, alu_ready, lsu_ready, exp_alu_rdy(), exp_lsu_rdy());
      end
      checks++;
      if (rs1_busy !== m_busy[rs1] || rs2_busy !== m_busy[rs2]) begin
        errors++; $display("FAIL rnd_query@%0d: rs1=%b rs2=%b expected %b/%b", n, rs1_busy, rs2_busy, m_busy[rs1], m_busy[rs2]);
      end
      tick();
      checks++;
      if (rf_we !== m_we || rf_rd !== m_rd || rf_wd !== m_wd || busy_vec !== m_busy) begin
        errors++; $display("FAIL rnd_state@%0d: we=%b rd=%0d wd=%h busy=%h expected %b/%0d/%h/%h",
                           n, rf_we, rf_rd, rf_wd, busy_vec, m_we, m_rd, m_wd, m_busy);
      end
      alu_hold = alu_valid && !m_alu_xfer && rst_n;
      lsu_hold = lsu_valid && !m_lsu_xfer && rst_n;
      rst_n = 1;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    m_last = c_LSU; m_busy = '0; m_we = 0; m_rd = '0; m_wd = '0;
    m_alu_xfer = 0; m_lsu_xfer = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_x0();
    test_set_clear();
    test_reset_mid();
    test_x0_issue();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
